// File: rtl/gpu_pkg.sv
// Shared framebuffer definitions: command opcodes, default geometry,
// coordinate widths and the coordinate clamp helpers.
package gpu_pkg;

    localparam int XW         = 9;
    localparam int YW         = 8;
    localparam int DEF_WIDTH  = 320;
    localparam int DEF_HEIGHT = 200;

    typedef enum logic [1:0] {
        OP_NOP   = 2'b00,
        OP_READ  = 2'b01,
        OP_WRITE = 2'b10,
        OP_FILL  = 2'b11
    } op_t;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_ISSUE = 3'd1,
        S_HOLD  = 3'd2,
        S_WAIT  = 3'd3,
        S_FIN   = 3'd4
    } seq_state_t;

    function automatic logic [XW-1:0] clamp_x(input logic [XW-1:0] v,
                                               input logic [XW-1:0] vmax);
        return (v > vmax) ? vmax : v;
    endfunction

    function automatic logic [YW-1:0] clamp_y(input logic [YW-1:0] v,
                                               input logic [YW-1:0] vmax);
        return (v > vmax) ? vmax : v;
    endfunction

endpackage

// File: rtl/fill_cursor.sv
// Raster cursor over an inclusive, pre-ordered rectangle. Single pixels are
// loaded as a 1x1 rectangle so o_last is high immediately.
module fill_cursor
    import gpu_pkg::*;
(
    input  logic          clk,
    input  logic          reset,
    input  logic          i_load,
    input  logic          i_step,
    input  logic [XW-1:0] i_x0,
    input  logic [XW-1:0] i_x1,
    input  logic [YW-1:0] i_y0,
    input  logic [YW-1:0] i_y1,
    output logic [XW-1:0] o_x,
    output logic [YW-1:0] o_y,
    output logic          o_last
);

    logic [XW-1:0] r_x;
    logic [XW-1:0] r_xs;
    logic [XW-1:0] r_xe;
    logic [YW-1:0] r_y;
    logic [YW-1:0] r_ye;
    logic          w_row_end;

    assign w_row_end = (r_x == r_xe);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_x  <= '0;
            r_xs <= '0;
            r_xe <= '0;
            r_y  <= '0;
            r_ye <= '0;
        end else if (i_load) begin
            r_x  <= i_x0;
            r_xs <= i_x0;
            r_xe <= i_x1;
            r_y  <= i_y0;
            r_ye <= i_y1;
        end else if (i_step) begin
            if (w_row_end) begin
                r_x <= r_xs;
                r_y <= r_y + 1'b1;
            end else begin
                r_x <= r_x + 1'b1;
            end
        end
    end

    assign o_x    = r_x;
    assign o_y    = r_y;
    assign o_last = w_row_end && (r_y == r_ye);

endmodule

// File: rtl/fb_port_seq.sv
// Port-B command sequencer for the 1-bit framebuffer: single-pixel read/write
// and rectangle fill expanded into raster-order pixel writes.
//
// state | meaning
// IDLE  | ready for a command
// ISSUE | waiting for rdy_b, then strobe read_b/write_b
// HOLD  | cycle after a strobe; RAM still reports the previous rdy_b
// WAIT  | waiting for rdy_b; capture read data or strobe next fill pixel
// FIN   | done pulse; a new command may be accepted here
module fb_port_seq
    import gpu_pkg::*;
#(
    parameter int WIDTH  = DEF_WIDTH,
    parameter int HEIGHT = DEF_HEIGHT
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          cmd_valid,
    output logic          cmd_ready,
    input  logic [1:0]    cmd_op,
    input  logic [XW-1:0] cmd_x0,
    input  logic [XW-1:0] cmd_x1,
    input  logic [YW-1:0] cmd_y0,
    input  logic [YW-1:0] cmd_y1,
    input  logic          cmd_color,
    output logic          done,
    output logic          rd_valid,
    output logic          rd_data,
    output logic [XW-1:0] x_b,
    output logic [YW-1:0] y_b,
    output logic          read_b,
    output logic          write_b,
    output logic          in_b,
    input  logic          rdy_b,
    input  logic          out_b
);

    localparam logic [XW-1:0] X_MAX = XW'(WIDTH - 1);
    localparam logic [YW-1:0] Y_MAX = YW'(HEIGHT - 1);

    seq_state_t    r_state;
    seq_state_t    w_next;
    op_t           r_op;
    logic          r_color;
    logic          r_pending;
    logic          r_rd_data;

    op_t           w_op_in;
    logic          w_accept;
    logic          w_fill;
    logic          w_load;
    logic          w_step;
    logic          w_last;
    logic [XW-1:0] w_cx0;
    logic [XW-1:0] w_cx1;
    logic [YW-1:0] w_cy0;
    logic [YW-1:0] w_cy1;
    logic [XW-1:0] w_lx0;
    logic [XW-1:0] w_lx1;
    logic [YW-1:0] w_ly0;
    logic [YW-1:0] w_ly1;

    assign w_op_in  = op_t'(cmd_op);
    assign w_accept = cmd_valid && cmd_ready;
    assign w_fill   = (w_op_in == OP_FILL);
    assign w_load   = w_accept && (w_op_in != OP_NOP);

    assign w_cx0 = clamp_x(cmd_x0, X_MAX);
    assign w_cx1 = clamp_x(cmd_x1, X_MAX);
    assign w_cy0 = clamp_y(cmd_y0, Y_MAX);
    assign w_cy1 = clamp_y(cmd_y1, Y_MAX);

    // Reads and writes become a 1x1 rectangle so the cursor drives every op.
    assign w_lx0 = (w_fill && (w_cx1 < w_cx0)) ? w_cx1 : w_cx0;
    assign w_lx1 = !w_fill ? w_cx0 : ((w_cx1 < w_cx0) ? w_cx0 : w_cx1);
    assign w_ly0 = (w_fill && (w_cy1 < w_cy0)) ? w_cy1 : w_cy0;
    assign w_ly1 = !w_fill ? w_cy0 : ((w_cy1 < w_cy0) ? w_cy0 : w_cy1);

    // Cursor advances during HOLD so the next pixel is on x_b/y_b by WAIT.
    assign w_step = (r_state == S_HOLD) && !w_last;

    fill_cursor u_cursor (
        .clk    (clk),
        .reset  (reset),
        .i_load (w_load),
        .i_step (w_step),
        .i_x0   (w_lx0),
        .i_x1   (w_lx1),
        .i_y0   (w_ly0),
        .i_y1   (w_ly1),
        .o_x    (x_b),
        .o_y    (y_b),
        .o_last (w_last)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_op      <= OP_NOP;
            r_color   <= 1'b0;
            r_pending <= 1'b0;
            r_rd_data <= 1'b0;
        end else begin
            if (w_accept) begin
                r_op <= w_op_in;
            end
            if (w_load) begin
                r_color <= cmd_color;
            end
            if (r_state == S_HOLD) begin
                r_pending <= !w_last;
            end
            if ((r_state == S_WAIT) && rdy_b && (r_op == OP_READ)) begin
                r_rd_data <= out_b;
            end
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    w_next = (w_op_in == OP_NOP) ? S_FIN : S_ISSUE;
                end
            end
            S_ISSUE: begin
                if (rdy_b) begin
                    w_next = S_HOLD;
                end
            end
            S_HOLD: begin
                w_next = S_WAIT;
            end
            S_WAIT: begin
                if (rdy_b) begin
                    w_next = r_pending ? S_HOLD : S_FIN;
                end
            end
            S_FIN: begin
                if (w_accept) begin
                    w_next = (w_op_in == OP_NOP) ? S_FIN : S_ISSUE;
                end else begin
                    w_next = S_IDLE;
                end
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    always_comb begin
        cmd_ready = 1'b0;
        done      = 1'b0;
        rd_valid  = 1'b0;
        read_b    = 1'b0;
        write_b   = 1'b0;
        case (r_state)
            S_IDLE: begin
                cmd_ready = 1'b1;
            end
            S_ISSUE: begin
                if (rdy_b) begin
                    read_b  = (r_op == OP_READ);
                    write_b = (r_op != OP_READ);
                end
            end
            S_WAIT: begin
                write_b = rdy_b && r_pending;
            end
            S_FIN: begin
                cmd_ready = 1'b1;
                done      = 1'b1;
                rd_valid  = (r_op == OP_READ);
            end
            default: begin
                cmd_ready = 1'b0;
            end
        endcase
    end

    assign in_b    = r_color;
    assign rd_data = r_rd_data;

endmodule

// File: tb/tb_fb_port_seq.sv
// Directed bench for fb_port_seq with a behavioural port-B RAM: write busy one
// cycle after the strobe, read busy two cycles with data shown when idle.
module tb_fb_port_seq;

    localparam int W = 320;
    localparam int H = 200;
    localparam logic [1:0] C_NOP   = 2'b00;
    localparam logic [1:0] C_READ  = 2'b01;
    localparam logic [1:0] C_WRITE = 2'b10;
    localparam logic [1:0] C_FILL  = 2'b11;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       cmd_valid = 1'b0;
    logic [1:0] cmd_op = 2'b00;
    logic [8:0] cmd_x0 = '0;
    logic [8:0] cmd_x1 = '0;
    logic [7:0] cmd_y0 = '0;
    logic [7:0] cmd_y1 = '0;
    logic       cmd_color = 1'b0;
    logic       cmd_ready, done, rd_valid, rd_data;
    logic [8:0] x_b;
    logic [7:0] y_b;
    logic       read_b, write_b, in_b, rdy_b, out_b;

    int cyc = 0;
    int n_checks = 0;
    int n_fail = 0;

    fb_port_seq dut (
        .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_op(cmd_op), .cmd_x0(cmd_x0), .cmd_x1(cmd_x1), .cmd_y0(cmd_y0),
        .cmd_y1(cmd_y1), .cmd_color(cmd_color), .done(done), .rd_valid(rd_valid),
        .rd_data(rd_data), .x_b(x_b), .y_b(y_b), .read_b(read_b), .write_b(write_b),
        .in_b(in_b), .rdy_b(rdy_b), .out_b(out_b)
    );

    always #5 clk = ~clk;

    logic mem [0:H-1][0:W-1];
    int   busy = 0;
    logic stall = 1'b0;
    logic rd_lat = 1'b0;

    assign rdy_b = (busy == 0) && !stall;
    assign out_b = (busy == 0) ? rd_lat : 1'b0;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (reset) begin
            busy   <= 0;
            rd_lat <= 1'b0;
            for (int i = 0; i < H; i++)
                for (int j = 0; j < W; j++)
                    mem[i][j] <= 1'b0;
        end else if (write_b) begin
            mem[y_b][x_b] <= in_b;
            busy <= 1;
        end else if (read_b) begin
            rd_lat <= mem[y_b][x_b];
            busy <= 2;
        end else if (busy > 0) begin
            busy <= busy - 1;
        end
    end

    typedef struct {int cyc; logic rd; logic [8:0] x; logic [7:0] y; logic d;} strobe_t;
    typedef struct {int cyc; logic rv; logic rdat;} done_t;
    strobe_t sq[$];
    done_t   dq[$];

    always @(negedge clk) begin
        if (!reset) begin
            if (read_b || write_b) begin
                n_checks++;
                if ((read_b && write_b) || !rdy_b) begin
                    n_fail++;
                    $display("FAIL strobe_rules cyc=%0d read_b=%b write_b=%b rdy_b=%b (need one strobe, rdy_b=1)",
                             cyc, read_b, write_b, rdy_b);
                end
                sq.push_back('{cyc, read_b, x_b, y_b, in_b});
            end
            if (done) dq.push_back('{cyc, rd_valid, rd_data});
        end
    end

    task automatic send(input logic [1:0] op, input int x0, input int y0,
                        input int x1, input int y1, input logic color, output int t0);
        @(negedge clk);
        cmd_op = op; cmd_x0 = 9'(x0); cmd_y0 = 8'(y0);
        cmd_x1 = 9'(x1); cmd_y1 = 8'(y1); cmd_color = color;
        cmd_valid = 1'b1;
        for (int k = 0; k < 200 && !cmd_ready; k++) @(negedge clk);
        n_checks++;
        if (cmd_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL accept_timeout cmd_ready=%b required 1", cmd_ready);
        end
        t0 = cyc;
        @(negedge clk);
        cmd_valid = 1'b0;
    endtask

    task automatic wait_done(input int limit, output done_t d);
        for (int k = 0; k < limit && dq.size() == 0; k++) @(posedge clk);
        n_checks++;
        if (dq.size() == 0) begin
            n_fail++;
            $display("FAIL done_timeout no done within %0d cycles", limit);
            d = '{-1, 1'b0, 1'b0};
        end else begin
            d = dq.pop_front();
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(negedge clk);
        n_checks += 9;
        if (cmd_ready !== 1'b1) begin n_fail++; $display("FAIL rst_cmd_ready got %b need 1", cmd_ready); end
        if (done !== 1'b0)      begin n_fail++; $display("FAIL rst_done got %b need 0", done); end
        if (rd_valid !== 1'b0)  begin n_fail++; $display("FAIL rst_rd_valid got %b need 0", rd_valid); end
        if (rd_data !== 1'b0)   begin n_fail++; $display("FAIL rst_rd_data got %b need 0", rd_data); end
        if (read_b !== 1'b0)    begin n_fail++; $display("FAIL rst_read_b got %b need 0", read_b); end
        if (write_b !== 1'b0)   begin n_fail++; $display("FAIL rst_write_b got %b need 0", write_b); end
        if (in_b !== 1'b0)      begin n_fail++; $display("FAIL rst_in_b got %b need 0", in_b); end
        if (x_b !== 9'd0)       begin n_fail++; $display("FAIL rst_x_b got %0d need 0", x_b); end
        if (y_b !== 8'd0)       begin n_fail++; $display("FAIL rst_y_b got %0d need 0", y_b); end
        reset = 1'b0;
    endtask

    task automatic test_nop();
        int t0; done_t d;
        send(C_NOP, 7, 7, 7, 7, 1'b1, t0);
        wait_done(20, d);
        repeat (3) @(posedge clk);
        n_checks += 4;
        if (d.cyc !== t0 + 1) begin n_fail++; $display("FAIL nop_done_cyc got %0d need %0d", d.cyc, t0 + 1); end
        if (d.rv !== 1'b0)    begin n_fail++; $display("FAIL nop_rd_valid got %b need 0", d.rv); end
        if (sq.size() != 0)   begin n_fail++; $display("FAIL nop_strobes got %0d need 0", sq.size()); end
        if (x_b !== 9'd0 || in_b !== 1'b0) begin
            n_fail++; $display("FAIL nop_bus x_b=%0d in_b=%b need 0/0", x_b, in_b);
        end
    endtask

    task automatic test_write_read();
        int t0; done_t d; strobe_t s;
        send(C_WRITE, 5, 7, 0, 0, 1'b1, t0);
        wait_done(50, d);
        n_checks += 3;
        if (d.cyc !== t0 + 4) begin n_fail++; $display("FAIL wr_done_cyc got %0d need %0d", d.cyc, t0 + 4); end
        if (d.rv !== 1'b0)    begin n_fail++; $display("FAIL wr_rd_valid got %b need 0", d.rv); end
        if (sq.size() != 1)   begin n_fail++; $display("FAIL wr_strobe_count got %0d need 1", sq.size()); end
        if (sq.size() > 0) begin
            s = sq.pop_front();
            n_checks++;
            if (s.cyc !== t0 + 1 || s.rd !== 1'b0 || s.x !== 9'd5 || s.y !== 8'd7 || s.d !== 1'b1) begin
                n_fail++;
                $display("FAIL wr_strobe got c%0d rd=%b (%0d,%0d) d=%b need c%0d rd=0 (5,7) d=1",
                         s.cyc - t0, s.rd, s.x, s.y, s.d, 1);
            end
        end
        send(C_READ, 5, 7, 0, 0, 1'b0, t0);
        wait_done(50, d);
        n_checks += 3;
        if (d.cyc !== t0 + 5) begin n_fail++; $display("FAIL rd_done_cyc got %0d need %0d", d.cyc, t0 + 5); end
        if (d.rv !== 1'b1)    begin n_fail++; $display("FAIL rd_valid got %b need 1", d.rv); end
        if (d.rdat !== 1'b1)  begin n_fail++; $display("FAIL rd_data got %b need 1", d.rdat); end
        if (sq.size() > 0) begin
            s = sq.pop_front();
            n_checks++;
            if (s.cyc !== t0 + 1 || s.rd !== 1'b1 || s.x !== 9'd5 || s.y !== 8'd7) begin
                n_fail++;
                $display("FAIL rd_strobe got c%0d rd=%b (%0d,%0d) need c1 rd=1 (5,7)", s.cyc - t0, s.rd, s.x, s.y);
            end
        end
        repeat (4) @(negedge clk);
        n_checks += 2;
        if (rd_data !== 1'b1) begin n_fail++; $display("FAIL rd_data_hold got %b need 1", rd_data); end
        if (rd_valid !== 1'b0 || done !== 1'b0) begin
            n_fail++; $display("FAIL pulse_width rd_valid=%b done=%b need 0/0", rd_valid, done);
        end
        sq.delete();
    endtask

    task automatic check_fill(input string name, input int t0, input int n,
                              input int ex[], input int ey[], input logic color);
        done_t d; strobe_t s;
        wait_done(200, d);
        repeat (6) @(posedge clk);
        n_checks += 3;
        if (d.cyc !== t0 + 2 * n + 2) begin
            n_fail++; $display("FAIL %s_done_cyc got %0d need %0d", name, d.cyc - t0, 2 * n + 2);
        end
        if (dq.size() != 0) begin n_fail++; $display("FAIL %s_extra_done got %0d need 0", name, dq.size()); end
        if (sq.size() != n) begin n_fail++; $display("FAIL %s_strobe_count got %0d need %0d", name, sq.size(), n); end
        for (int i = 0; i < n && sq.size() > 0; i++) begin
            s = sq.pop_front();
            n_checks++;
            if (s.cyc !== t0 + 1 + 2 * i || s.rd !== 1'b0 || s.x !== 9'(ex[i]) ||
                s.y !== 8'(ey[i]) || s.d !== color) begin
                n_fail++;
                $display("FAIL %s_pix%0d got c%0d rd=%b (%0d,%0d) d=%b need c%0d rd=0 (%0d,%0d) d=%b",
                         name, i, s.cyc - t0, s.rd, s.x, s.y, s.d, 1 + 2 * i, ex[i], ey[i], color);
            end
        end
        sq.delete();
        dq.delete();
    endtask

    task automatic test_fill();
        int t0;
        int ex[] = '{2, 3, 4, 2, 3, 4};
        int ey[] = '{1, 1, 1, 2, 2, 2};
        send(C_FILL, 2, 1, 4, 2, 1'b1, t0);
        check_fill("fill", t0, 6, ex, ey, 1'b1);
    endtask

    task automatic test_fill_swap_clamp();
        int t0; done_t d;
        int ex[] = '{2, 3, 4, 2, 3, 4};
        int ey[] = '{1, 1, 1, 2, 2, 2};
        int cx[] = '{318, 319, 318, 319};
        int cy[] = '{198, 198, 199, 199};
        send(C_FILL, 4, 2, 2, 1, 1'b0, t0);
        check_fill("swap", t0, 6, ex, ey, 1'b0);
        send(C_READ, 3, 2, 0, 0, 1'b0, t0);
        wait_done(50, d);
        n_checks++;
        if (d.rdat !== 1'b0) begin n_fail++; $display("FAIL swap_readback got %b need 0", d.rdat); end
        sq.delete();
        send(C_FILL, 318, 198, 500, 255, 1'b1, t0);
        check_fill("clamp", t0, 4, cx, cy, 1'b1);
        send(C_READ, 400, 250, 0, 0, 1'b0, t0);
        wait_done(50, d);
        n_checks += 2;
        if (d.rdat !== 1'b1) begin n_fail++; $display("FAIL clamp_readback got %b need 1", d.rdat); end
        if (sq.size() != 1 || sq[0].x !== 9'd319 || sq[0].y !== 8'd199) begin
            n_fail++; $display("FAIL clamp_read_addr strobes=%0d need one at (319,199)", sq.size());
        end
        sq.delete();
    endtask

    task automatic test_stall();
        int t0, rel; done_t d;
        stall = 1'b1;
        send(C_WRITE, 10, 20, 0, 0, 1'b1, t0);
        repeat (4) @(negedge clk);
        cmd_op = C_READ; cmd_x0 = 9'd1; cmd_y0 = 8'd1; cmd_valid = 1'b1;
        n_checks++;
        if (cmd_ready !== 1'b0) begin n_fail++; $display("FAIL busy_cmd_ready got %b need 0", cmd_ready); end
        @(negedge clk);
        cmd_valid = 1'b0;
        repeat (5) @(negedge clk);
        n_checks++;
        if (sq.size() != 0) begin n_fail++; $display("FAIL stall_strobe got %0d need 0", sq.size()); end
        @(posedge clk);
        #1 stall = 1'b0;
        rel = cyc;
        wait_done(50, d);
        repeat (10) @(posedge clk);
        n_checks += 4;
        if (d.cyc !== rel + 3) begin n_fail++; $display("FAIL stall_done_cyc got %0d need %0d", d.cyc - rel, 3); end
        if (sq.size() != 1)    begin n_fail++; $display("FAIL stall_strobe_count got %0d need 1", sq.size()); end
        else if (sq[0].cyc !== rel || sq[0].x !== 9'd10 || sq[0].y !== 8'd20) begin
            n_fail++; $display("FAIL stall_strobe got c%0d (%0d,%0d) need c0 (10,20)", sq[0].cyc - rel, sq[0].x, sq[0].y);
        end
        if (dq.size() != 0) begin n_fail++; $display("FAIL ignored_cmd_ran extra done=%0d need 0", dq.size()); end
        if (mem[20][10] !== 1'b1) begin n_fail++; $display("FAIL stall_mem got %b need 1", mem[20][10]); end
        sq.delete();
    endtask

    task automatic test_reset_mid_fill();
        int t0; done_t d;
        send(C_FILL, 0, 0, 9, 0, 1'b1, t0);
        for (int k = 0; k < 100 && sq.size() < 3; k++) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        n_checks += 5;
        if (cmd_ready !== 1'b1) begin n_fail++; $display("FAIL mid_cmd_ready got %b need 1", cmd_ready); end
        if (write_b !== 1'b0 || read_b !== 1'b0) begin
            n_fail++; $display("FAIL mid_strobes write_b=%b read_b=%b need 0/0", write_b, read_b);
        end
        if (x_b !== 9'd0 || y_b !== 8'd0) begin n_fail++; $display("FAIL mid_xy got (%0d,%0d) need (0,0)", x_b, y_b); end
        if (in_b !== 1'b0) begin n_fail++; $display("FAIL mid_in_b got %b need 0", in_b); end
        if (done !== 1'b0) begin n_fail++; $display("FAIL mid_done got %b need 0", done); end
        reset = 1'b0;
        sq.delete();
        dq.delete();
        repeat (20) @(posedge clk);
        n_checks++;
        if (dq.size() != 0 || sq.size() != 0) begin
            n_fail++; $display("FAIL mid_abandon done=%0d strobes=%0d need 0/0", dq.size(), sq.size());
        end
        send(C_WRITE, 1, 1, 0, 0, 1'b1, t0);
        wait_done(50, d);
        n_checks += 2;
        if (d.cyc !== t0 + 4) begin n_fail++; $display("FAIL post_rst_done got %0d need 4", d.cyc - t0); end
        if (sq.size() != 1 || sq[0].cyc !== t0 + 1) begin
            n_fail++; $display("FAIL post_rst_strobe count=%0d need one at c1", sq.size());
        end
        sq.delete();
    endtask

    task automatic test_back_to_back();
        int t0, t1; done_t d0, d1;
        @(negedge clk);
        cmd_op = C_READ; cmd_x0 = 9'd1; cmd_y0 = 8'd1; cmd_valid = 1'b1;
        t0 = cyc;
        @(negedge clk);
        cmd_op = C_WRITE; cmd_x0 = 9'd6; cmd_y0 = 8'd7; cmd_color = 1'b1;
        for (int k = 0; k < 50 && !cmd_ready; k++) @(negedge clk);
        t1 = cyc;
        @(negedge clk);
        cmd_valid = 1'b0;
        wait_done(50, d0);
        wait_done(50, d1);
        repeat (4) @(posedge clk);
        n_checks += 5;
        if (t1 !== t0 + 5) begin n_fail++; $display("FAIL b2b_accept got c%0d need c5", t1 - t0); end
        if (d0.cyc !== t0 + 5 || d0.rv !== 1'b1 || d0.rdat !== 1'b1) begin
            n_fail++; $display("FAIL b2b_read_done got c%0d rv=%b d=%b need c5 rv=1 d=1", d0.cyc - t0, d0.rv, d0.rdat);
        end
        if (d1.cyc !== t0 + 9 || d1.rv !== 1'b0) begin
            n_fail++; $display("FAIL b2b_write_done got c%0d rv=%b need c9 rv=0", d1.cyc - t0, d1.rv);
        end
        if (sq.size() != 2) begin n_fail++; $display("FAIL b2b_strobe_count got %0d need 2", sq.size()); end
        else if (sq[0].cyc !== t0 + 1 || sq[0].rd !== 1'b1 || sq[1].cyc !== t0 + 6 ||
                 sq[1].rd !== 1'b0 || sq[1].x !== 9'd6 || sq[1].y !== 8'd7) begin
            n_fail++; $display("FAIL b2b_strobes got c%0d rd=%b / c%0d rd=%b (%0d,%0d) need c1 rd=1 / c6 rd=0 (6,7)",
                               sq[0].cyc - t0, sq[0].rd, sq[1].cyc - t0, sq[1].rd, sq[1].x, sq[1].y);
        end
        if (mem[7][6] !== 1'b1) begin n_fail++; $display("FAIL b2b_mem got %b need 1", mem[7][6]); end
        sq.delete();
    endtask

    initial begin
        test_reset();
        test_nop();
        test_write_read();
        test_fill();
        test_fill_swap_clamp();
        test_stall();
        test_reset_mid_fill();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
